// File: rtl/alu_result_sel_if.sv
// ---------------------------------------------------------------------------
// alu_result_sel_if
// Handshake bundle for alu_result_sel_pipe.
//   in_valid / in_ready : input handshake (producer -> pipe)
//   in_data             : NUM_IN packed candidates, candidate k at [k*WIDTH +: WIDTH]
//   in_sel              : operation select, looked up in the pipe's map table
//   out_valid/out_ready : output handshake (pipe -> consumer)
//   out_data            : selected candidate (zero when unmapped)
//   out_unmapped        : select had no valid map entry
// Modports: slave = the pipe itself, master = the side driving it.
// ---------------------------------------------------------------------------
interface alu_result_sel_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 4
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_unmapped;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_unmapped
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_unmapped
    );
endinterface

// File: rtl/alu_result_sel_pipe.sv
// ---------------------------------------------------------------------------
// alu_result_sel_pipe
// Picks one of NUM_IN candidate ALU results through a programmable map table
// indexed by the operation select, and registers it behind a valid/ready
// output. Latency is one cycle from acceptance to out_valid.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : alu_result_sel_if.slave (input/output handshakes and data)
//   cfg_we     : map table write strobe
//   cfg_addr   : map entry to write (select value)
//   cfg_idx    : candidate index stored in the entry
//   cfg_vld    : entry valid bit
//
// Build option
//   ALU_RESULT_SEL_SKID_EN : when defined, a two-entry skid buffer is used and
//   in_ready comes straight from a flop (no out_ready -> in_ready path).
//   When undefined, a single output register with
//   in_ready = ~out_valid | out_ready.
//
// LEGACY_MAP=1 is only meaningful with SEL_W=4 and NUM_IN=8.
// ---------------------------------------------------------------------------
module alu_result_sel_pipe #(
    parameter int WIDTH      = 32,
    parameter int NUM_IN     = 8,
    parameter int SEL_W      = 4,
    parameter bit LEGACY_MAP = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_result_sel_if.slave           bus,
    input  logic                      cfg_we,
    input  logic [SEL_W-1:0]          cfg_addr,
    input  logic [$clog2(NUM_IN)-1:0] cfg_idx,
    input  logic                      cfg_vld
);
    localparam int IDX_W = $clog2(NUM_IN);
    localparam int DEPTH = 1 << SEL_W;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } map_entry_t;

    // Reset contents of map entry i.
    function automatic map_entry_t map_reset_entry(input int i);
        map_entry_t e;
        e = '0;
        if (LEGACY_MAP) begin
            e.vld = 1'b1;
            case (i)
                0:       e.idx = IDX_W'(0);
                1:       e.idx = IDX_W'(1);
                2:       e.idx = IDX_W'(2);
                3:       e.idx = IDX_W'(3);
                4:       e.idx = IDX_W'(4);
                5:       e.idx = IDX_W'(1);
                6:       e.idx = IDX_W'(5);
                7:       e.idx = IDX_W'(6);
                8:       e.idx = IDX_W'(0);
                10:      e.idx = IDX_W'(7);
                13:      e.idx = IDX_W'(1);
                default: e.vld = 1'b0;
            endcase
        end else if (i < NUM_IN) begin
            e.vld = 1'b1;
            e.idx = IDX_W'(i);
        end
        return e;
    endfunction

    map_entry_t map_q [DEPTH];

    // A write lands at the clock edge, so an input accepted in the same cycle
    // still reads the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                map_q[i] <= map_reset_entry(i);
            end
        end else if (cfg_we) begin
            map_q[cfg_addr] <= {cfg_vld, cfg_idx};
        end
    end

    // in_ready stays low through reset and rises on the first edge after.
    logic alive_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive_q <= 1'b0;
        else        alive_q <= 1'b1;
    end

    // ---- stage p0: combinational lookup and candidate select ----
    map_entry_t       ent_p0;
    logic             hit_p0;
    logic             unmapped_p0;
    logic [WIDTH-1:0] sel_data_p0;
    logic             in_acc_p0;
    logic             out_free_p1;

    // An index >= NUM_IN never matches any k, so it falls out as unmapped.
    always_comb begin
        ent_p0      = map_q[bus.in_sel];
        hit_p0      = 1'b0;
        sel_data_p0 = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ent_p0.vld && (ent_p0.idx == IDX_W'(k))) begin
                hit_p0      = 1'b1;
                sel_data_p0 = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
        unmapped_p0 = ~hit_p0;
    end

    assign in_acc_p0 = bus.in_valid & bus.in_ready;

    // ---- stage p1: output register (plus optional skid entry) ----
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             unm_p1;

    assign out_free_p1 = ~vld_p1 | bus.out_ready;

`ifdef ALU_RESULT_SEL_SKID_EN
    logic             skid_vld_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_unm_q;

    // Ready only depends on flops: the skid slot absorbs the one result that
    // may arrive in the cycle the consumer stalls.
    assign bus.in_ready = alive_q & ~skid_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            unm_p1     <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (out_free_p1) begin
            if (skid_vld_q) begin
                // Skid is full means in_ready was low: no new input this cycle.
                vld_p1     <= 1'b1;
                data_p1    <= skid_data_q;
                unm_p1     <= skid_unm_q;
                skid_vld_q <= 1'b0;
            end else begin
                vld_p1 <= in_acc_p0;
                if (in_acc_p0) begin
                    data_p1 <= sel_data_p0;
                    unm_p1  <= unmapped_p0;
                end
            end
        end else if (in_acc_p0) begin
            skid_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_acc_p0 && !out_free_p1) begin
            skid_data_q <= sel_data_p0;
            skid_unm_q  <= unmapped_p0;
        end
    end
`else
    assign bus.in_ready = alive_q & out_free_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            unm_p1  <= 1'b0;
        end else if (out_free_p1) begin
            vld_p1 <= in_acc_p0;
            if (in_acc_p0) begin
                data_p1 <= sel_data_p0;
                unm_p1  <= unmapped_p0;
            end
        end
    end
`endif

    assign bus.out_valid    = vld_p1;
    assign bus.out_data     = data_p1;
    assign bus.out_unmapped = unm_p1;
endmodule
